// File: rtl/id_serialize_ctrl.sv
// id_serialize_ctrl: gates ID-stage fetch acceptance so serializing
// instructions (CSR, FENCE, FENCE.I, WFI, SFENCE.VMA, xRET) issue alone.
// A serializing instruction waits for the pipeline to drain, issues from
// slot 0 by itself, then holds younger instructions until it commits.
// A watchdog returns to idle if the commit never arrives.
// Optional feature macro: ID_SERIAL_PERF_EN enables the stall cycle counter
// on stall_cnt_o; without it stall_cnt_o is tied to zero.

module id_serialize_ctrl #(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned MAX_WAIT    = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic [ISSUE_WIDTH-1:0] fetch_valid_i,
  input  logic [ISSUE_WIDTH-1:0] serial_i,
  input  logic [ISSUE_WIDTH-1:0] sent_i,
  input  logic                   issue_empty_i,
  input  logic                   sb_empty_i,
  input  logic                   commit_serial_i,
  output logic [ISSUE_WIDTH-1:0] allow_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [ISSUE_WIDTH-1:0] ser_hit;
  logic [ISSUE_WIDTH-1:0] idle_allow;
  logic [ISSUE_WIDTH-1:0] allow_c;

  // Only slot 0 handshake advances the FSM; the rest is observed for completeness.
  logic unused_sent;
  assign unused_sent = ^sent_i;

  assign ser_hit = fetch_valid_i & serial_i;

  // Allow every slot older than the oldest valid serializing instruction.
  always_comb begin
    logic found;
    found      = 1'b0;
    idle_allow = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      if (!found) begin
        if (ser_hit[i]) begin
          found = 1'b1;
        end else begin
          idle_allow[i] = 1'b1;
        end
      end
    end
  end

  // Next-state, watchdog and acceptance mask; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
    allow_c    = '0;

    unique case (state_q)
      S_IDLE: begin
        allow_c = idle_allow;
        if (ser_hit[0]) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (issue_empty_i && sb_empty_i) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        allow_c = ISSUE_WIDTH'(1);
        if (sent_i[0]) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (commit_serial_i) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase

    if (flush_i) begin
      state_d    = S_IDLE;
      wait_cnt_d = '0;
      timeout_d  = 1'b0;
      allow_c    = '0;
    end
  end

  // State, watchdog counter and timeout pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign allow_o   = allow_c;
  assign busy_o    = (state_q != S_IDLE);
  assign timeout_o = timeout_q;

`ifdef ID_SERIAL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count drain and wait cycles, saturating; flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == S_DRAIN) || (state_q == S_WAIT)) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_serialize_ctrl.sv
// Self-checking bench for id_serialize_ctrl. Main instance uses the default
// watchdog; a second instance with MAX_WAIT=8 covers watchdog expiry.
// Each task queues stimulus and expected outputs, then replays cycle by cycle.

module tb_id_serialize_ctrl;

`ifdef ID_SERIAL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [1:0]  fetch_valid_i;
  logic [1:0]  serial_i;
  logic [1:0]  sent_i;
  logic        issue_empty_i;
  logic        sb_empty_i;
  logic        commit_serial_i;

  logic [1:0]  allow_o;
  logic        busy_o;
  logic        timeout_o;
  logic [31:0] stall_cnt_o;

  logic [1:0]  wd_allow_o;
  logic        wd_busy_o;
  logic        wd_timeout_o;
  logic [31:0] wd_stall_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [9:0]  stim_q[$];
  logic [3:0]  exp_q[$];
  logic [31:0] stall_q[$];

  id_serialize_ctrl #(.ISSUE_WIDTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .serial_i(serial_i), .sent_i(sent_i),
    .issue_empty_i(issue_empty_i), .sb_empty_i(sb_empty_i),
    .commit_serial_i(commit_serial_i),
    .allow_o(allow_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .stall_cnt_o(stall_cnt_o)
  );

  id_serialize_ctrl #(.ISSUE_WIDTH(2), .MAX_WAIT(8)) dut_wd (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .serial_i(serial_i), .sent_i(sent_i),
    .issue_empty_i(issue_empty_i), .sb_empty_i(sb_empty_i),
    .commit_serial_i(commit_serial_i),
    .allow_o(wd_allow_o), .busy_o(wd_busy_o), .timeout_o(wd_timeout_o),
    .stall_cnt_o(wd_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [9:0] st(input logic fl, input logic [1:0] fv,
                                    input logic [1:0] se, input logic [1:0] sn,
                                    input logic ie, input logic sb, input logic cm);
    return {fl, fv, se, sn, ie, sb, cm};
  endfunction

  function automatic logic [3:0] ex(input logic [1:0] al, input logic bz, input logic to);
    return {al, bz, to};
  endfunction

  task automatic drive(input logic [9:0] v);
    {flush_i, fetch_valid_i, serial_i, sent_i, issue_empty_i, sb_empty_i, commit_serial_i} = v;
  endtask

  task automatic test_reset();
    drive(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({allow_o, busy_o, timeout_o} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 1100", {allow_o, busy_o, timeout_o});
    end
    checks++;
    if (stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", stall_cnt_o);
    end
    checks++;
    if ({wd_allow_o, wd_busy_o, wd_timeout_o, wd_stall_cnt_o} !== {4'b1100, 32'd0}) begin
      errors++;
      $display("FAIL reset_wd: got %b/%0d want 1100/0", {wd_allow_o, wd_busy_o, wd_timeout_o}, wd_stall_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if ({allow_o, busy_o, timeout_o} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release: got %b want 1100", {allow_o, busy_o, timeout_o});
    end
  endtask

  task automatic test_partial_allow();
    logic [3:0] e;
    int cyc = 0;
    stim_q.push_back(st(0, 2'b00, 2'b11, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    stim_q.push_back(st(0, 2'b10, 2'b10, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b01, 0, 0));
    stim_q.push_back(st(0, 2'b11, 2'b10, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b01, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 1)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    while (stim_q.size() != 0) begin
      @(negedge clk_i);
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({allow_o, busy_o, timeout_o} !== e) begin
        errors++;
        $display("FAIL partial_allow cyc %0d: got allow/busy/tmo %b want %b", cyc, {allow_o, busy_o, timeout_o}, e);
      end
      cyc++;
    end
  endtask

  task automatic test_drain();
    logic [3:0] e;
    int cyc = 0;
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 0, 1)); exp_q.push_back(ex(2'b00, 1, 0));
    for (int i = 0; i < 4; i++) begin
      stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    end
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    stim_q.push_back(st(0, 2'b11, 2'b11, 2'b10, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 1)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    while (stim_q.size() != 0) begin
      @(negedge clk_i);
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({allow_o, busy_o, timeout_o} !== e) begin
        errors++;
        $display("FAIL drain cyc %0d: got allow/busy/tmo %b want %b", cyc, {allow_o, busy_o, timeout_o}, e);
      end
      cyc++;
    end
  endtask

  task automatic test_commit();
    logic [3:0] e;
    int cyc = 0;
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    for (int i = 0; i < 10; i++) begin
      stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    end
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 1)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    while (stim_q.size() != 0) begin
      @(negedge clk_i);
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({allow_o, busy_o, timeout_o} !== e) begin
        errors++;
        $display("FAIL commit cyc %0d: got allow/busy/tmo %b want %b", cyc, {allow_o, busy_o, timeout_o}, e);
      end
      cyc++;
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] e;
    int cyc = 0;
    int pulses = 0;
    stim_q.push_back(st(1, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    for (int i = 0; i < 8; i++) begin
      stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    end
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 1));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    // Commit lands on the expiry cycle: commit wins, no pulse.
    stim_q.push_back(st(1, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    for (int i = 0; i < 7; i++) begin
      stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    end
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 1)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    while (stim_q.size() != 0) begin
      @(negedge clk_i);
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      if (wd_timeout_o === 1'b1) pulses++;
      checks++;
      if ({wd_allow_o, wd_busy_o, wd_timeout_o} !== e) begin
        errors++;
        $display("FAIL watchdog cyc %0d: got allow/busy/tmo %b want %b", cyc, {wd_allow_o, wd_busy_o, wd_timeout_o}, e);
      end
      if (cyc == 12) begin
        checks++;
        if ({busy_o, timeout_o} !== 2'b10) begin
          errors++;
          $display("FAIL watchdog_long_limit: got busy/tmo %b want 10", {busy_o, timeout_o});
        end
      end
      cyc++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL watchdog_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_flush();
    logic [3:0] e;
    int cyc = 0;
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(1, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    stim_q.push_back(st(1, 2'b11, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b11, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(1, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0));
    while (stim_q.size() != 0) begin
      @(negedge clk_i);
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({allow_o, busy_o, timeout_o} !== e) begin
        errors++;
        $display("FAIL flush cyc %0d: got allow/busy/tmo %b want %b", cyc, {allow_o, busy_o, timeout_o}, e);
      end
      cyc++;
    end
  endtask

  task automatic test_stall();
    logic [3:0]  e;
    logic [31:0] s;
    int cyc = 0;
    // Park in S_WAIT, then reset mid-operation.
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 0, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0));
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0));
    while (stim_q.size() != 0) begin
      @(negedge clk_i);
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({allow_o, busy_o, timeout_o} !== e) begin
        errors++;
        $display("FAIL stall_setup cyc %0d: got allow/busy/tmo %b want %b", cyc, {allow_o, busy_o, timeout_o}, e);
      end
      cyc++;
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({allow_o, busy_o, timeout_o, stall_cnt_o} !== {4'b1100, 32'd0}) begin
      errors++;
      $display("FAIL midop_reset: got %b/%0d want 1100/0", {allow_o, busy_o, timeout_o}, stall_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Three drain cycles, four wait cycles.
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0)); stall_q.push_back(0);
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0)); stall_q.push_back(0);
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0)); stall_q.push_back(1);
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b00, 1, 1, 0)); exp_q.push_back(ex(2'b00, 1, 0)); stall_q.push_back(2);
    stim_q.push_back(st(0, 2'b01, 2'b01, 2'b01, 0, 0, 0)); exp_q.push_back(ex(2'b01, 1, 0)); stall_q.push_back(3);
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0)); stall_q.push_back(3);
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0)); stall_q.push_back(4);
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 1, 0)); stall_q.push_back(5);
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 1)); exp_q.push_back(ex(2'b00, 1, 0)); stall_q.push_back(6);
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0)); stall_q.push_back(7);
    stim_q.push_back(st(1, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b00, 0, 0)); stall_q.push_back(7);
    stim_q.push_back(st(0, 2'b00, 2'b00, 2'b00, 0, 0, 0)); exp_q.push_back(ex(2'b11, 0, 0)); stall_q.push_back(7);
    cyc = 0;
    while (stim_q.size() != 0) begin
      @(negedge clk_i);
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      s = PERF ? stall_q.pop_front() : 32'd0;
      if (!PERF) void'(stall_q.pop_front());
      checks++;
      if ({allow_o, busy_o, timeout_o} !== e) begin
        errors++;
        $display("FAIL stall_seq cyc %0d: got allow/busy/tmo %b want %b", cyc, {allow_o, busy_o, timeout_o}, e);
      end
      checks++;
      if (stall_cnt_o !== s) begin
        errors++;
        $display("FAIL stall_cnt cyc %0d: got %0d want %0d", cyc, stall_cnt_o, s);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_partial_allow();
    test_drain();
    test_commit();
    test_watchdog();
    test_flush();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
